saturating_accumulator: RTL

Multi-channel accumulator generalising the saturating add. It keeps a private running sum per channel, updates one channel per accepted input, and has two modes: clamp-to-ceiling (saturate) or modulo 2^WIDTH (wrap). It sits behind event/statistics counters feeding datapath control and reports a per-channel sticky overflow flag.

---
 rtl/saturating_accumulator_pkg.sv | 29 ++
 rtl/saturating_accumulator_clamp_add_unit.sv | 48 ++++
 rtl/saturating_accumulator.sv | 128 ++++++++++++
 3 files changed

// File: rtl/saturating_accumulator_pkg.sv
// Shared constants and helpers for the multi-channel saturating accumulator:
// mode encoding, output field layout and channel-index width.
package saturating_accumulator_pkg;

    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    // Packed output layout, LSB upwards: sticky, sat_now, sum, ch, valid.
    localparam int STICKY_BIT = 0;
    localparam int SAT_BIT    = 1;
    localparam int SUM_LSB    = 2;

    function automatic int ch_bits_f(input int channels);
        if (channels <= 1) begin
            return 1;
        end else begin
            return $clog2(channels);
        end
    endfunction

    function automatic int ch_lsb_f(input int width);
        return SUM_LSB + width;
    endfunction

    function automatic int out_w_f(input int width, input int ch_bits);
        return ch_bits + width + 3;
    endfunction

endpackage

// File: rtl/saturating_accumulator_clamp_add_unit.sv
// Combinational update for one accumulator: add or load, then clamp to the
// ceiling (saturate mode) or keep the low bits and report the carry (wrap mode).
module clamp_add_unit
    import saturating_accumulator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic [WIDTH-1:0] max_i,
    input  logic             wrap_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] next_acc_o,
    output logic             sat_now_o
);

    logic [WIDTH:0] sum_s;

    // Select the new accumulator value and the saturation/carry indication.
    always_comb begin
        sum_s      = {1'b0, acc_i} + {1'b0, value_i};
        next_acc_o = acc_i;
        sat_now_o  = 1'b0;
        if (clear_i) begin
            if (wrap_i == MODE_WRAP) begin
                next_acc_o = value_i;
                sat_now_o  = 1'b0;
            end else if (value_i > max_i) begin
                next_acc_o = max_i;
                sat_now_o  = 1'b1;
            end else begin
                next_acc_o = value_i;
                sat_now_o  = 1'b0;
            end
        end else if (wrap_i == MODE_WRAP) begin
            next_acc_o = sum_s[WIDTH-1:0];
            sat_now_o  = sum_s[WIDTH];
        end else if (sum_s > {1'b0, max_i}) begin
            // Also catches an accumulator left above a ceiling that was lowered.
            next_acc_o = max_i;
            sat_now_o  = 1'b1;
        end else begin
            next_acc_o = sum_s[WIDTH-1:0];
            sat_now_o  = 1'b0;
        end
    end

endmodule

// File: rtl/saturating_accumulator.sv
// Multi-channel accumulator with per-op saturate/wrap mode, per-channel sticky
// overflow flags and a registered, packed result word.
module saturating_accumulator
    import saturating_accumulator_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                                             _i_clk,
    input  logic                                             _i_rst_n,
    input  logic                                             _i_valid,
    input  logic [ch_bits_f(CHANNELS)-1:0]                   _i_ch,
    input  logic [WIDTH-1:0]                                 _i_value,
    input  logic [WIDTH-1:0]                                 _i_max,
    input  logic                                             _i_wrap,
    input  logic                                             _i_clear,
    output logic [out_w_f(WIDTH, ch_bits_f(CHANNELS))-1:0]   __output
);

    localparam int CH_BITS = ch_bits_f(CHANNELS);
    localparam int OUT_W   = out_w_f(WIDTH, CH_BITS);
    localparam int CH_LSB  = ch_lsb_f(WIDTH);
    localparam logic [CH_BITS:0] CH_LIMIT = (CH_BITS + 1)'(CHANNELS);

    logic [WIDTH-1:0]    acc_q [CHANNELS];
    logic [WIDTH-1:0]    acc_d [CHANNELS];
    logic [CHANNELS-1:0] sticky_q, sticky_d;

    logic               out_valid_q, out_valid_d;
    logic [CH_BITS-1:0] out_ch_q, out_ch_d;
    logic [WIDTH-1:0]   out_sum_q, out_sum_d;
    logic               out_sat_q, out_sat_d;
    logic               out_sticky_q, out_sticky_d;

    logic               accept_s;
    logic [CH_BITS-1:0] ch_idx_s;
    logic [WIDTH-1:0]   next_acc_s;
    logic               sat_now_s;
    logic               sticky_new_s;

    // Range-check the channel; an out-of-range index is steered to 0 so the
    // read never leaves the array, and the op is dropped anyway.
    always_comb begin
        accept_s = 1'b0;
        ch_idx_s = '0;
        if (_i_valid && ({1'b0, _i_ch} < CH_LIMIT)) begin
            accept_s = 1'b1;
            ch_idx_s = _i_ch;
        end else begin
            accept_s = 1'b0;
            ch_idx_s = '0;
        end
    end

    clamp_add_unit #(
        .WIDTH (WIDTH)
    ) u_clamp_add (
        .acc_i      (acc_q[ch_idx_s]),
        .value_i    (_i_value),
        .max_i      (_i_max),
        .wrap_i     (_i_wrap),
        .clear_i    (_i_clear),
        .next_acc_o (next_acc_s),
        .sat_now_o  (sat_now_s)
    );

    // Next-state for channel storage and the output fields.
    always_comb begin
        acc_d        = acc_q;
        sticky_d     = sticky_q;
        sticky_new_s = 1'b0;
        out_valid_d  = 1'b0;
        out_ch_d     = out_ch_q;
        out_sum_d    = out_sum_q;
        out_sat_d    = out_sat_q;
        out_sticky_d = out_sticky_q;
        if (accept_s) begin
            // A load restarts the sticky history before this op's flag is merged.
            if (_i_clear) begin
                sticky_new_s = sat_now_s;
            end else begin
                sticky_new_s = sticky_q[ch_idx_s] | sat_now_s;
            end
            acc_d[ch_idx_s]    = next_acc_s;
            sticky_d[ch_idx_s] = sticky_new_s;
            out_valid_d        = 1'b1;
            out_ch_d           = ch_idx_s;
            out_sum_d          = next_acc_s;
            out_sat_d          = sat_now_s;
            out_sticky_d       = sticky_new_s;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
            sticky_q     <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_sum_q    <= '0;
            out_sat_q    <= 1'b0;
            out_sticky_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            sticky_q     <= sticky_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_sum_q    <= out_sum_d;
            out_sat_q    <= out_sat_d;
            out_sticky_q <= out_sticky_d;
        end
    end

    always_comb begin
        __output                        = '0;
        __output[OUT_W-1]               = out_valid_q;
        __output[CH_LSB +: CH_BITS]     = out_ch_q;
        __output[SUM_LSB +: WIDTH]      = out_sum_q;
        __output[SAT_BIT]               = out_sat_q;
        __output[STICKY_BIT]            = out_sticky_q;
    end

endmodule
